// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the multiply sequencer: Hack ALU control words and
// the sequencer state encoding.
package alu_mul_seq_pkg;

  // ALU control words, packed as {zx, nx, zy, ny, f, no}.
  localparam logic [5:0] ALU_ZERO      = 6'b101010;
  localparam logic [5:0] ALU_ONE       = 6'b111111;
  localparam logic [5:0] ALU_MINUS_ONE = 6'b111010;
  localparam logic [5:0] ALU_X         = 6'b001100;
  localparam logic [5:0] ALU_Y         = 6'b110000;
  localparam logic [5:0] ALU_NOTX      = 6'b001101;
  localparam logic [5:0] ALU_NOTY      = 6'b110001;
  localparam logic [5:0] ALU_NEG_X     = 6'b001111;
  localparam logic [5:0] ALU_NEG_Y     = 6'b110011;
  localparam logic [5:0] ALU_X_PLUS_1  = 6'b011111;
  localparam logic [5:0] ALU_Y_PLUS_1  = 6'b110111;
  localparam logic [5:0] ALU_X_MINUS_1 = 6'b001110;
  localparam logic [5:0] ALU_Y_MINUS_1 = 6'b110010;
  localparam logic [5:0] ALU_ADD       = 6'b000010;
  localparam logic [5:0] ALU_X_MINUS_Y = 6'b010011;
  localparam logic [5:0] ALU_Y_MINUS_X = 6'b000111;
  localparam logic [5:0] ALU_X_AND_Y   = 6'b000000;
  localparam logic [5:0] ALU_X_OR_Y    = 6'b010101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADD   = 3'd2,
    ST_DBL   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// The existing 16-bit Hack-style combinational ALU.
module alu_mul_seq_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x1, x2, y1, y2, fo;

  always_comb begin
    x1  = zx ? 16'h0000 : x;
    x2  = nx ? ~x1 : x1;
    y1  = zy ? 16'h0000 : y;
    y2  = ny ? ~y1 : y1;
    fo  = f ? (x2 + y2) : (x2 & y2);
    out = no ? ~fo : fo;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add 16-bit multiplier; every addition (accumulate and
// multiplicand doubling) is done by the shared ALU in x+y mode.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             zr,
  output logic             ng
);

  generate
    if (WIDTH != 16) begin : g_bad_width
      $error("alu_mul_seq: WIDTH must be 16 to match the ALU");
    end
  endgenerate

  state_t      state;
  logic [15:0] acc, mcand, mplier;
  logic [4:0]  count;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        unused_alu_zr, unused_alu_ng;

  // Only the accumulate step adds acc; otherwise the ALU doubles mcand.
  assign alu_x = (state == ST_ADD) ? acc : mcand;
  assign alu_y = mcand;

  alu_mul_seq_alu u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .zx  (ALU_ADD[5]),
    .nx  (ALU_ADD[4]),
    .zy  (ALU_ADD[3]),
    .ny  (ALU_ADD[2]),
    .f   (ALU_ADD[1]),
    .no  (ALU_ADD[0]),
    .out (alu_out),
    .zr  (unused_alu_zr),
    .ng  (unused_alu_ng)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (((EARLY_EXIT != 0) && (mplier == 16'h0000)) || (count == 5'd16)) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (mplier[0]) begin
            state <= ST_ADD;
          end else begin
            state <= ST_DBL;
          end
        end
        ST_ADD: begin
          acc   <= alu_out;
          state <= ST_DBL;
        end
        ST_DBL: begin
          mcand  <= alu_out;
          mplier <= {1'b0, mplier[15:1]};
          count  <= count + 5'd1;
          state  <= ST_CHECK;
        end
        ST_DONE: begin
          product <= acc;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign zr = (product == '0);
  assign ng = product[WIDTH-1];

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: expected product and latency are queued
// when a start is accepted and compared when done pulses.
module tb_alu_mul_seq;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, zr, ng;
  logic [15:0] product;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zr      (zr),
    .ng      (ng)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_latency(input logic [15:0] mb);
    int k = -1;
    int p = 0;
    for (int i = 0; i < 16; i++) begin
      if (mb[i]) begin
        k = i;
        p++;
      end
    end
    return 2 * (k + 1) + p + 2;
  endfunction

  function automatic logic [15:0] model_product(input logic [15:0] ma, input logic [15:0] mb);
    logic [31:0] full;
    full = ma * mb;
    return full[15:0];
  endfunction

  // Called at a negedge while the DUT is in IDLE; the next posedge accepts.
  task automatic drive_start(input logic [15:0] ta, input logic [15:0] tb_v);
    exp_t e;
    a = ta;
    b = tb_v;
    start = 1'b1;
    e.prod = model_product(ta, tb_v);
    e.lat  = model_latency(tb_v);
    sb.push_back(e);
  endtask

  // Entered at the first negedge after acceptance (cycle 1).
  task automatic collect(input bit poke_busy, input bit start_in_done);
    int   cyc = 1;
    exp_t e;
    while (!done && cyc < 80) begin
      check_val("busy_during_op", busy, 1'b1);
      if (poke_busy && cyc == 3) begin
        a = 16'h0001;
        b = 16'h0001;
        start = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (poke_busy && cyc == 4) start = 1'b0;
    end
    if (!done) begin
      check_val("done_timeout", 32'(cyc), 32'd0);
      return;
    end
    if (sb.size() == 0) begin
      check_val("unexpected_done", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    check_val("latency", 32'(cyc), 32'(e.lat));
    check_val("busy_in_done", busy, 1'b1);
    if (start_in_done) drive_start(16'h0002, 16'h0003);
    @(negedge clk);
    check_val("product", product, e.prod);
    check_val("zr", zr, (e.prod == 16'h0000));
    check_val("ng", ng, e.prod[15]);
    check_val("done_pulse_end", done, 1'b0);
    check_val("busy_after", busy, 1'b0);
    $display("op a=0x%04h b=0x%04h product=0x%04h latency=%0d", a, b, product, cyc);
    if (start_in_done) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input bit poke_busy);
    drive_start(ta, tb_v);
    @(negedge clk);
    start = 1'b0;
    collect(poke_busy, 1'b0);
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_product", product, 16'h0000);
    check_val("rst_zr", zr, 1'b1);
    check_val("rst_ng", ng, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_busy", busy, 1'b0);

    run_op(16'h0003, 16'h0005, 1'b0);
    run_op(16'h1234, 16'h0000, 1'b0);
    run_op(16'h0000, 16'h00FF, 1'b0);
    run_op(16'hFFFD, 16'h0007, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'h0100, 16'h0100, 1'b0);
    run_op(16'h0011, 16'h0003, 1'b0);
    run_op(16'h0006, 16'h0007, 1'b1);

    // Start raised in the DONE cycle is ignored; held into IDLE it is taken.
    drive_start(16'h0005, 16'h0009);
    @(negedge clk);
    start = 1'b0;
    collect(1'b0, 1'b1);
    collect(1'b0, 1'b0);

    // Abort mid-operation with reset.
    a = 16'h00FF;
    b = 16'h00FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_done", done, 1'b0);
    check_val("abort_product", product, 16'h0000);
    check_val("abort_zr", zr, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check_val("no_done_after_abort", seen_done, 1'b0);
    run_op(16'h0002, 16'h0003, 1'b0);

    check_val("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16-bit multiply sequencer built around the existing combinational ALU.
- Performs shift-and-add multiplication. Every addition (accumulate and multiplicand doubling) goes through the ALU, driven with its x+y control word.
- Only the multiplier right-shift uses local logic.
- Sits beside the CPU datapath as the multiply helper; result is the low 16 bits of the product, identical for signed and unsigned operands.

Parameters:
- WIDTH, 16, datapath width. Fixed at 16 to match the ALU; any other value is a configuration error.
- EARLY_EXIT, 1, when 1 the sequence terminates as soon as the remaining multiplier is 0; when 0 it always runs 16 iterations.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- a  in  16  multiplicand, captured when start is accepted
- b  in  16  multiplier, captured when start is accepted
- busy  out  1  high from the cycle after acceptance until DONE is left
- done  out  1  one-cycle pulse, product valid
- product  out  16  registered result, held until the next accepted start
- zr  out  1  product == 0 (combinational from product)
- ng  out  1  product[15]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc, mcand, mplier, count, product all 0.
  - busy=0, done=0, zr=1, ng=0.
  - Reset mid-operation aborts immediately; no done pulse follows.
- Registers: acc[15:0], mcand[15:0], mplier[15:0], count[4:0].
- ALU drive, single instance:
  - Control word is always zx=0, nx=0, zy=0, ny=0, f=1, no=0 (x+y).
  - ADD state: x=acc, y=mcand.
  - All other states: x=mcand, y=mcand.
  - Carry out of bit 15 is discarded (mod 2^16).
- FSM states: IDLE, CHECK, ADD, DBL, DONE.
  - IDLE: busy=0. On start=1: acc<=0, mcand<=a, mplier<=b, count<=0; go to CHECK. start=0 stays in IDLE.
  - CHECK:
    - If (EARLY_EXIT && mplier==0) or count==16, go to DONE.
    - Else if mplier[0]=1, go to ADD.
    - Else go to DBL.
  - ADD: acc<=ALU out; go to DBL.
  - DBL: mcand<=ALU out (mcand<<1); mplier<=mplier>>1 with zero fill; count<=count+1; go to CHECK.
  - DONE: product<=acc; done=1 for exactly this cycle; go to IDLE. product/zr/ng reflect the new value from the following cycle.
- busy=1 in CHECK, ADD, DBL, DONE.
- start while busy is ignored: not queued, operands not recaptured.
- start in the same cycle DONE exits is also ignored; it must be re-presented in IDLE.
- Latency, EARLY_EXIT=1: done is high N cycles after the start-sampling edge, N = 2*(k+1) + p + 2.
  - k = index of the highest set bit of b (k=-1 for b=0); p = popcount(b).
  - b=0 gives N=2. Worst case b=0xFFFF gives N=50.
- EARLY_EXIT=0: N = 32 + p + 2.
- Operand changes on a/b after acceptance have no effect.

Decomposition:
- Shared include alu_ctrl.vh holds:
  - ALU control-word constants: ALU_ADD=6'b000010 plus the other Hack encodings (ZERO, ONE, X, Y, NOTX, X_MINUS_Y, X_AND_Y, ...) for reuse by later controllers.
  - FSM state encodings, 3-bit: IDLE=0, CHECK=1, ADD=2, DBL=3, DONE=4.
- Sub-module: the existing ALU, instantiated once, unmodified. No other sub-modules.

Test Plan:
- Reset, then a=3, b=5, start for 1 cycle -> done exactly 10 cycles later; product=0x000F, zr=0, ng=0; busy high for the whole interval.
- a=0x1234, b=0 -> done after 2 cycles; product=0, zr=1. Then a=0, b=0x00FF -> product=0, done after 2*8+8+2=26 cycles.
- a=0xFFFD (-3), b=7 -> product=0xFFEB (-21), ng=1. Then a=0xFFFF, b=0xFFFF -> product=0x0001, done after 50 cycles.
- a=0x0100, b=0x0100 (wrap) -> product=0x0000, zr=1. Then a=0x0011, b=0x0003 -> product=0x0033.
- Back-to-back/ignored start:
  - Start 6*7; pulse start with a=1, b=1 while busy -> ignored, product=0x002A.
  - A start in the DONE cycle is also ignored; a start held into IDLE is accepted next cycle.
- Reset mid-op: start 0x00FF*0x00FF, drop rst_n 5 cycles later -> immediately busy=0, product=0, zr=1; no done pulse afterward. After release, 2*3 gives 0x0006.
